// File: rtl/fifo_reader.sv
// Read-side controller for a FIFO: drains BURST_LEN words per start pulse,
// issuing at most one read every other cycle so the FIFO's one-cycle read
// latency and lagging empty flag are absorbed, and presents the words on a
// valid/ready stream through a 2-entry output buffer.
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  start,
  input  logic                  FIFO_empty,
  input  logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  burst_done,
  output logic [CNT_WIDTH-1:0]  words_read
);

  localparam logic [7:0] BURST = 8'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              issued_q, issued_d;
  logic [7:0]              delivered_q, delivered_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              occ_q, occ_d;
  logic [DATA_WIDTH-1:0]   buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0]   buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]    words_q, words_d;
  logic                    pop;
  logic                    cap;

  assign data_valid = (occ_q != 2'd0);
  assign data_out   = buf0_q;
  assign busy       = (state_q != IDLE);
  assign burst_done = (state_q == DONE);
  assign words_read = words_q;

  // Read strobe, pop and capture qualifiers; all gated by the global enable.
  always_comb begin
    read_enable = 1'b0;
    pop         = 1'b0;
    cap         = 1'b0;
    if (Enable) begin
      read_enable = (state_q == ACTIVE) && !FIFO_empty && !inflight_q &&
                    (occ_q < 2'd2) && (issued_q < BURST);
      pop         = data_valid && data_ready;
      cap         = inflight_q;
    end
  end

  // Burst FSM with issued/delivered bookkeeping and the running word counter.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    inflight_d  = inflight_q;
    words_d     = words_q;
    if (Enable) begin
      inflight_d = read_enable;
      if (read_enable) issued_d = issued_q + 8'd1;
      if (pop) begin
        delivered_d = delivered_q + 8'd1;
        words_d     = words_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = ACTIVE;
            issued_d    = 8'd0;
            delivered_d = 8'd0;
          end
        end
        ACTIVE:  if (issued_q == BURST) state_d = DRAIN;
        DRAIN:   if (delivered_q == BURST) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Two-entry output buffer; head always lives in buf0 so data_out is a register.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({cap, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = FIFO_data_out;
        else               buf1_d = FIFO_data_out;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = FIFO_data_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = FIFO_data_out;
        end
      end
      default: ;
    endcase
  end

  // State registers; asynchronous reset abandons any burst in progress.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      issued_q    <= 8'd0;
      delivered_q <= 8'd0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      words_q     <= words_d;
    end
  end

endmodule
